icache_fill_ctrl: RTL and testbench

//  Direct-mapped, one-word-per-block instruction cache for one core. Sits between
//  the datapath fetch port and one core's instruction port on the coherence/arbiter
//  (iREN/iaddr/iwait/iload). On a hit it answers the datapath with no wait. On a

---
 rtl/icache_fill_ctrl_if.sv | 24 ++
 rtl/icache_fill_ctrl.sv | 82 ++++++++
 tb/tb_icache_fill_ctrl.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/icache_fill_ctrl_if.sv
// icache_fill_ctrl_if: datapath fetch port, arbiter fill port and statistics of the instruction cache
interface icache_fill_ctrl_if;
    logic        dp_imemREN;
    logic [31:0] dp_imemaddr;
    logic        dp_ihit;
    logic [31:0] dp_imemload;
    logic        icache_flush;
    logic        cc_iREN;
    logic [31:0] cc_iaddr;
    logic        cc_iwait;
    logic [31:0] cc_iload;
    logic [31:0] hit_cnt;
    logic [31:0] miss_cnt;

    modport master (
        output dp_imemREN, dp_imemaddr, icache_flush, cc_iwait, cc_iload,
        input  dp_ihit, dp_imemload, cc_iREN, cc_iaddr, hit_cnt, miss_cnt
    );

    modport slave (
        input  dp_imemREN, dp_imemaddr, icache_flush, cc_iwait, cc_iload,
        output dp_ihit, dp_imemload, cc_iREN, cc_iaddr, hit_cnt, miss_cnt
    );
endinterface

// File: rtl/icache_fill_ctrl.sv
// icache_fill_ctrl: direct-mapped one-word-per-line instruction cache with single-word miss fill
module icache_fill_ctrl #(
    parameter  int SETS  = 16,
    localparam int IDX_W = $clog2(SETS),
    localparam int TAG_W = 30 - IDX_W
) (
    input logic CLK,
    input logic nRST,
    icache_fill_ctrl_if.slave bus
);
    typedef enum logic {IDLE, FILL} state_t;

    state_t            state_q, state_d;
    logic [SETS-1:0]   valid_q, valid_d;
    logic [TAG_W-1:0]  tag_q [SETS];
    logic [31:0]       data_q [SETS];
    logic [31:0]       miss_addr_q, miss_addr_d;
    logic [31:0]       hit_cnt_q, hit_cnt_d;
    logic [31:0]       miss_cnt_q, miss_cnt_d;
    logic [IDX_W-1:0]  idx, fidx;
    logic [TAG_W-1:0]  tag, ftag;
    logic              hit, fill_done;

    assign idx       = bus.dp_imemaddr[IDX_W+1:2];
    assign tag       = bus.dp_imemaddr[31:IDX_W+2];
    assign fidx      = miss_addr_q[IDX_W+1:2];
    assign ftag      = miss_addr_q[31:IDX_W+2];
    assign hit       = state_q == IDLE && bus.dp_imemREN && valid_q[idx] && tag_q[idx] == tag;
    assign fill_done = state_q == FILL && !bus.cc_iwait;

    assign bus.dp_ihit     = hit;
    assign bus.dp_imemload = hit ? data_q[idx] : 32'h0;
    assign bus.cc_iREN     = state_q == FILL;
    assign bus.cc_iaddr    = state_q == FILL ? miss_addr_q : 32'h0;
    assign bus.hit_cnt     = hit_cnt_q;
    assign bus.miss_cnt    = miss_cnt_q;

    // Next state: start a fill on a non-flushed miss, finish it when the arbiter drops iwait; flush overrides the refill valid bit
    always_comb begin
        state_d     = state_q;
        valid_d     = valid_q;
        miss_addr_d = miss_addr_q;
        hit_cnt_d   = hit && hit_cnt_q != '1 ? hit_cnt_q + 32'd1 : hit_cnt_q;
        miss_cnt_d  = miss_cnt_q;
        if (state_q == IDLE && bus.dp_imemREN && !hit && !bus.icache_flush) begin
            state_d     = FILL;
            miss_addr_d = bus.dp_imemaddr & ~32'h3;
            miss_cnt_d  = miss_cnt_q != '1 ? miss_cnt_q + 32'd1 : miss_cnt_q;
        end
        if (fill_done) begin
            state_d       = IDLE;
            valid_d[fidx] = 1'b1;
        end
        if (bus.icache_flush)
            valid_d = '0;
    end

    // Control state, valid bits and counters; async reset aborts any fill in flight
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q     <= IDLE;
            valid_q     <= '0;
            miss_addr_q <= '0;
            hit_cnt_q   <= '0;
            miss_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            valid_q     <= valid_d;
            miss_addr_q <= miss_addr_d;
            hit_cnt_q   <= hit_cnt_d;
            miss_cnt_q  <= miss_cnt_d;
        end
    end

    // Tag and data arrays are only meaningful under a valid bit, so they carry no reset
    always_ff @(posedge CLK) begin
        if (fill_done) begin
            tag_q[fidx]  <= ftag;
            data_q[fidx] <= bus.cc_iload;
        end
    end
endmodule

// File: tb/tb_icache_fill_ctrl.sv
// tb_icache_fill_ctrl: per-cycle vector table plus hand-written flush and reset sequences
module tb_icache_fill_ctrl;
    logic CLK = 0;
    logic nRST = 0;
    int   checks = 0;
    int   errors = 0;

    icache_fill_ctrl_if bus ();
    icache_fill_ctrl #(.SETS(16)) dut (.CLK(CLK), .nRST(nRST), .bus(bus));

    always #5 CLK = ~CLK;

    typedef struct {
        logic        ren;
        logic [31:0] addr;
        logic        iwait;
        logic [31:0] iload;
        logic        flush;
        logic        e_hit;
        logic [31:0] e_load;
        logic        e_ren;
        logic [31:0] e_iaddr;
        logic [31:0] e_hc;
        logic [31:0] e_mc;
    } vec_t;

    vec_t vq[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic add(input logic ren, input logic [31:0] addr, input logic iwait, input logic [31:0] iload,
                       input logic flush, input logic e_hit, input logic [31:0] e_load, input logic e_ren,
                       input logic [31:0] e_iaddr, input logic [31:0] e_hc, input logic [31:0] e_mc);
        vq.push_back('{ren, addr, iwait, iload, flush, e_hit, e_load, e_ren, e_iaddr, e_hc, e_mc});
    endtask

    task automatic drive(input logic ren, input logic [31:0] addr, input logic iwait, input logic [31:0] iload, input logic flush);
        bus.dp_imemREN   = ren;
        bus.dp_imemaddr  = addr;
        bus.cc_iwait     = iwait;
        bus.cc_iload     = iload;
        bus.icache_flush = flush;
    endtask

    initial begin
        drive(0, 0, 1, 0, 0);
        // miss on 0x40, three-cycle fill, then a hit
        add(1, 32'h40,  1, 0,            0, 0, 0,            0, 0,      0, 0);
        add(1, 32'h40,  1, 0,            0, 0, 0,            1, 32'h40, 0, 1);
        add(1, 32'h40,  1, 0,            0, 0, 0,            1, 32'h40, 0, 1);
        add(1, 32'h40,  0, 32'h11111111, 0, 0, 0,            1, 32'h40, 0, 1);
        add(1, 32'h40,  1, 0,            0, 1, 32'h11111111, 0, 0,      0, 1);
        // repeated hits
        for (int i = 1; i <= 5; i++)
            add(1, 32'h40, 1, 0, 0, 1, 32'h11111111, 0, 0, i, 1);
        add(0, 32'h40,  1, 0,            0, 0, 0,            0, 0,      6, 1);
        // conflict eviction at index 0
        add(1, 32'h440, 1, 0,            0, 0, 0,            0, 0,      6, 1);
        add(1, 32'h440, 0, 32'h22222222, 0, 0, 0,            1, 32'h440,6, 2);
        add(1, 32'h440, 1, 0,            0, 1, 32'h22222222, 0, 0,      6, 2);
        add(1, 32'h40,  1, 0,            0, 0, 0,            0, 0,      7, 2);
        add(1, 32'h40,  0, 32'h11111111, 0, 0, 0,            1, 32'h40, 7, 3);
        add(1, 32'h40,  1, 0,            0, 1, 32'h11111111, 0, 0,      7, 3);
        // address changes mid-fill
        add(1, 32'h80,  1, 0,            0, 0, 0,            0, 0,      8, 3);
        add(1, 32'h84,  1, 0,            0, 0, 0,            1, 32'h80, 8, 4);
        add(1, 32'h84,  0, 32'h33333333, 0, 0, 0,            1, 32'h80, 8, 4);
        add(1, 32'h84,  1, 0,            0, 0, 0,            0, 0,      8, 4);
        add(1, 32'h84,  0, 32'h44444444, 0, 0, 0,            1, 32'h84, 8, 5);
        add(1, 32'h84,  1, 0,            0, 1, 32'h44444444, 0, 0,      8, 5);
        add(1, 32'h80,  1, 0,            0, 1, 32'h33333333, 0, 0,      9, 5);
        // flush on the fill-complete edge
        add(1, 32'hC0,  1, 0,            0, 0, 0,            0, 0,      10, 5);
        add(1, 32'hC0,  0, 32'h55555555, 1, 0, 0,            1, 32'hC0, 10, 6);
        add(1, 32'hC0,  1, 0,            0, 0, 0,            0, 0,      10, 6);
        add(1, 32'hC0,  0, 32'h55555555, 0, 0, 0,            1, 32'hC0, 10, 7);
        add(1, 32'hC0,  1, 0,            0, 1, 32'h55555555, 0, 0,      10, 7);
        // flush in IDLE: hit judged on old contents, then everything invalid
        add(1, 32'hC0,  1, 0,            1, 1, 32'h55555555, 0, 0,      11, 7);
        add(1, 32'hC0,  1, 0,            0, 0, 0,            0, 0,      12, 7);
        add(1, 32'hC0,  0, 32'h66666666, 0, 0, 0,            1, 32'hC0, 12, 8);
        add(1, 32'h84,  1, 0,            0, 0, 0,            0, 0,      12, 8);

        #1;
        chk("rst_ihit", {31'b0, bus.dp_ihit}, 0);
        chk("rst_load", bus.dp_imemload, 0);
        chk("rst_iren", {31'b0, bus.cc_iREN}, 0);
        chk("rst_iaddr", bus.cc_iaddr, 0);
        chk("rst_hc", bus.hit_cnt, 0);
        chk("rst_mc", bus.miss_cnt, 0);
        @(posedge CLK); #1;
        nRST = 1;

        foreach (vq[i]) begin
            drive(vq[i].ren, vq[i].addr, vq[i].iwait, vq[i].iload, vq[i].flush);
            #1;
            chk($sformatf("v%0d_ihit", i), {31'b0, bus.dp_ihit}, {31'b0, vq[i].e_hit});
            chk($sformatf("v%0d_load", i), bus.dp_imemload, vq[i].e_load);
            chk($sformatf("v%0d_iren", i), {31'b0, bus.cc_iREN}, {31'b0, vq[i].e_ren});
            chk($sformatf("v%0d_iaddr", i), bus.cc_iaddr, vq[i].e_iaddr);
            chk($sformatf("v%0d_hc", i), bus.hit_cnt, vq[i].e_hc);
            chk($sformatf("v%0d_mc", i), bus.miss_cnt, vq[i].e_mc);
            @(posedge CLK); #1;
        end

        // now in FILL for 0x84: reset aborts the request asynchronously
        drive(1, 32'h84, 1, 0, 0);
        #1;
        chk("pre_rst_iren", {31'b0, bus.cc_iREN}, 1);
        chk("pre_rst_iaddr", bus.cc_iaddr, 32'h84);
        nRST = 0;
        #1;
        chk("async_rst_iren", {31'b0, bus.cc_iREN}, 0);
        chk("async_rst_iaddr", bus.cc_iaddr, 0);
        chk("async_rst_hc", bus.hit_cnt, 0);
        chk("async_rst_mc", bus.miss_cnt, 0);
        @(posedge CLK); #1;
        nRST = 1;

        // flush blocks a miss in IDLE
        drive(1, 32'hC0, 1, 0, 1);
        #1;
        chk("fl_miss_ihit", {31'b0, bus.dp_ihit}, 0);
        @(posedge CLK); #1;
        drive(1, 32'hC0, 1, 0, 0);
        #1;
        chk("fl_miss_iren", {31'b0, bus.cc_iREN}, 0);
        chk("fl_miss_mc", bus.miss_cnt, 0);
        chk("post_rst_ihit", {31'b0, bus.dp_ihit}, 0);
        @(posedge CLK); #1;
        chk("post_rst_iren", {31'b0, bus.cc_iREN}, 1);
        chk("post_rst_iaddr", bus.cc_iaddr, 32'hC0);
        chk("post_rst_mc", bus.miss_cnt, 1);
        bus.cc_iwait = 0;
        bus.cc_iload = 32'h77777777;
        @(posedge CLK); #1;
        bus.cc_iwait = 1;
        #1;
        chk("post_rst_hit", {31'b0, bus.dp_ihit}, 1);
        chk("post_rst_load", bus.dp_imemload, 32'h77777777);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
